// File: rtl/uart_defs_pkg.sv
// uart_defs: shared UART state encoding and default parameters for the transmit and receive sides
package uart_defs;
    localparam int OVERSAMPLE  = 16;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int DVSR_DEF    = 27;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: mod-DVSR counter producing a one-clk oversampling tick, held at zero by clr
module uart_baud_gen #(
    parameter int DVSR = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DVSR);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DVSR - 1);
    // count clk cycles, restarting on each tick or while cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops FIFO words while idle and sends them as UART frames; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_fifo_drain
    import uart_defs::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR    = DVSR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_dout,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);
    // the tick counter widens beyond 4 bits only for stop bits longer than one bit time
    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] BIT_END  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
    state_t state, state_n;
    logic [SW-1:0] s, s_n;
    logic [NW-1:0] n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic tx_n, tick, idle, par_bit;
    assign idle    = state == IDLE;
    assign tx_busy = ~idle;
    uart_baud_gen #(.DVSR(DVSR)) u_baud (
        .clk  (clk),
        .reset(reset),
        .clr  (idle),
        .tick (tick)
    );
`ifdef UART_TX_PARITY_EN
    logic p;
    assign par_bit = p;
    // parity is taken from the word as it is popped, so later shifting cannot disturb it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) p <= 1'b0;
        else if (fifo_rd) p <= ^fifo_dout;
    end
`else
    assign par_bit = 1'b1;
`endif
    // frame state, counters, shift register and the registered line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            s     <= s_n;
            n     <= n_n;
            b     <= b_n;
            tx    <= tx_n;
        end
    end
    // next-state logic; tx is derived from the next state so the line changes with the state
    always_comb begin
        state_n      = state;
        s_n          = s;
        n_n          = n;
        b_n          = b;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        case (state)
            IDLE: begin
                fifo_rd = ~fifo_empty & ~reset;
                if (!fifo_empty) begin
                    state_n = START;
                    b_n     = fifo_dout;
                    s_n     = '0;
                end
            end
            START: if (tick) begin
                s_n = (s == BIT_END) ? '0 : s + SW'(1);
                if (s == BIT_END) begin
                    state_n = DATA;
                    n_n     = '0;
                end
            end
            DATA: if (tick) begin
                s_n = (s == BIT_END) ? '0 : s + SW'(1);
                if (s == BIT_END) begin
                    b_n = b >> 1;
                    n_n = n + NW'(1);
`ifdef UART_TX_PARITY_EN
                    if (n == NW'(DBIT - 1)) state_n = PARITY;
`else
                    if (n == NW'(DBIT - 1)) state_n = STOP;
`endif
                end
            end
            PARITY: if (tick) begin
                s_n = (s == BIT_END) ? '0 : s + SW'(1);
                if (s == BIT_END) state_n = STOP;
            end
            STOP: if (tick) begin
                s_n = (s == STOP_END) ? '0 : s + SW'(1);
                if (s == STOP_END) begin
                    state_n      = IDLE;
                    tx_done_tick = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        tx_n = (state_n == START)  ? 1'b0 :
               (state_n == DATA)   ? b_n[0] :
               (state_n == PARITY) ? par_bit : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: vector table and scoreboard bench for uart_tx_fifo_drain (honours UART_TX_PARITY_EN)
module tb_uart_tx_fifo_drain;
    localparam int DV = 4;
    localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB   = DB + 2 + P;
    localparam int FL   = (16 * (DB + 1 + P) + 16) * DV;
    localparam int FL_B = (16 * (DB + 1 + P) + 32) * DV;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       last;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] mem_a [32];
    logic [7:0] mem_b [32];
    int wa = 0, ra = 0, wb = 0, rb = 0;
    logic empty_a, empty_b, rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
    logic [7:0] dout_a, dout_b;
    int checks = 0, errors = 0;
    int cyc = 0, rd_cnt = 0, done_cnt = 0;
    vec_t exp_q[$];

    assign empty_a = (wa == ra);
    assign dout_a  = mem_a[ra % 32];
    assign empty_b = (wb == rb);
    assign dout_b  = mem_b[rb % 32];

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR(DV)) u_a (
        .clk(clk), .reset(reset), .fifo_empty(empty_a), .fifo_dout(dout_a),
        .fifo_rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );
    uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .DVSR(DV)) u_b (
        .clk(clk), .reset(reset), .fifo_empty(empty_b), .fifo_dout(dout_b),
        .fifo_rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    // FIFO models: the head advances on each pop strobe
    always @(posedge clk) begin
        if (rd_a) ra <= ra + 1;
        if (rd_b) rb <= rb + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        mem_a[wa % 32] = d;
        wa++;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 1);
    endtask

    // monitor on DUT A: pop strobe rules, frame length, back-to-back gap and a serial decoder
    int t_rd = -1, dc = 0;
    logic prev_done = 1'b0, prev_rd = 1'b0, dbusy = 1'b0;
    logic [15:0] got = '0;
    always @(negedge clk) begin
        vec_t e;
        cyc++;
        if (reset) begin
            dbusy = 1'b0;
            t_rd = -1;
            prev_done = 1'b0;
            prev_rd = 1'b0;
        end else begin
            if (rd_a) begin
                rd_cnt++;
                chk("rd_while_empty", 32'(empty_a), 0);
                chk("rd_width", 32'(prev_rd), 0);
                t_rd = cyc;
            end
            if (prev_done && !empty_a) chk("b2b_gap_rd", 32'(rd_a), 1);
            if (done_a) begin
                done_cnt++;
                if (t_rd >= 0) chk("frame_len", 32'(cyc - t_rd), 32'(FL));
                t_rd = -1;
            end
            if (!dbusy) begin
                if (tx_a == 1'b0) begin
                    dbusy = 1'b1;
                    dc = 0;
                end
            end else dc++;
            if (dbusy && dc % 64 == 32) begin
                got[dc / 64] = tx_a;
                if (dc / 64 == NB - 1) begin
                    dbusy = 1'b0;
                    if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("frame_bits", {22'd0, got[NB-1], got[8:1], got[0]}, {22'd0, 1'b1, e.data, 1'b0});
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", 32'(got[9]), 32'(e.par));
`endif
                    end
                end
            end
            prev_done = done_a;
            prev_rd = rd_a;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tv [6];
        vec_t v;
        int n, base_rd, base_done, bad, t, ones;
        tv[0] = '{8'hA5, 1'b0, 1'b1};
        tv[1] = '{8'h00, 1'b0, 1'b0};
        tv[2] = '{8'hFF, 1'b0, 1'b0};
        tv[3] = '{8'h3C, 1'b0, 1'b1};
        tv[4] = '{8'h07, 1'b1, 1'b1};
        tv[5] = '{8'h03, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 1);
        chk("rst_rd", 32'(rd_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!tx_a || rd_a || busy_a || done_a || !tx_b || rd_b || busy_b) bad++;
        end
        chk("empty_quiet", 32'(bad), 0);

        n = 0;
        base_rd = rd_cnt;
        base_done = done_cnt;
        for (int i = 0; i < 6; i++) begin
            push_a(tv[i].data);
            exp_q.push_back(tv[i]);
            n++;
            if (tv[i].last) begin
                wait_done(base_done + n);
                chk("group_rd_count", 32'(rd_cnt - base_rd), 32'(n));
                chk("group_done_count", 32'(done_cnt - base_done), 32'(n));
                repeat (5) @(negedge clk);
                chk("idle_after_group", {30'd0, busy_a, tx_a}, 32'd1);
                base_rd = rd_cnt;
                base_done = done_cnt;
                n = 0;
            end
        end

        push_a(8'h55);
        push_a(8'h99);
        v = '{8'h99, 1'b0, 1'b1};
        exp_q.push_back(v);
        t = 0;
        while (!busy_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_frame_started", 32'(busy_a), 1);
        repeat (200) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx_a), 1);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_rd", 32'(rd_a), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_done(base_done + 1);
        chk("midrst_rd_total", 32'(rd_cnt - base_rd), 2);
        chk("midrst_sb_empty", 32'(exp_q.size()), 0);
        repeat (5) @(negedge clk);

        mem_b[wb % 32] = 8'h81;
        wb++;
        #1;
        chk("b_rd", 32'(rd_b), 1);
        @(posedge clk);
        t = 0;
        ones = 0;
        do begin
            @(negedge clk);
            t++;
            if (t > 16 * (DB + 1 + P) * DV && tx_b) ones++;
        end while (!done_b && t < 5000);
        chk("b_frame_len", 32'(t), 32'(FL_B));
        chk("b_stop_len", 32'(ones), 32'(32 * DV));
        @(negedge clk);
        chk("b_idle", 32'(busy_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
